// File: rtl/sr_using_jk_ff_pkg.sv
// Shared S=R=1 resolution policy encodings for the SR-over-JK flip-flop bank.
package sr_using_jk_ff_pkg;

    localparam int unsigned SR_HOLD     = 0;
    localparam int unsigned SR_TOGGLE   = 1;
    localparam int unsigned SR_SET_WINS = 2;
    localparam int unsigned SR_RST_WINS = 3;

endpackage

// File: rtl/sr_using_jk_ff_jk.sv
// WIDTH-wide JK flip-flop core: hold / clear / set / toggle per bit.
module jk_ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    // Characteristic equation q+ = j&~q | ~k&q covers all four JK cases bitwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end

    assign qbar = ~q;

endmodule

// File: rtl/sr_using_jk_ff.sv
// Clocked SR flip-flop bank: maps S/R onto J/K by the selected S=R=1 policy and drives one jk_ff.
module sr_using_jk_ff
    import sr_using_jk_ff_pkg::*;
#(
    parameter int unsigned WIDTH        = 1,
    parameter int unsigned SR_BOTH_MODE = SR_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] sr_conflict
);

    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    generate
        if (SR_BOTH_MODE == SR_TOGGLE) begin : g_toggle
            always_comb begin
                j = s;
                k = r;
            end
        end else if (SR_BOTH_MODE == SR_SET_WINS) begin : g_set_wins
            always_comb begin
                j = s;
                k = r & ~s;
            end
        end else if (SR_BOTH_MODE == SR_RST_WINS) begin : g_rst_wins
            always_comb begin
                j = s & ~r;
                k = r;
            end
        end else begin : g_hold
            // Also the fallback for out-of-range modes: S=R=1 gives J=K=0.
            always_comb begin
                j = s & ~r;
                k = r & ~s;
            end
        end
    endgenerate

    assign sr_conflict = s & r;

    jk_ff #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rst_n(rst_n),
        .j    (j),
        .k    (k),
        .q    (q),
        .qbar (qbar)
    );

endmodule

// File: tb/tb_sr_using_jk_ff.sv
// Self-checking bench: directed single-bit sequences plus a 4-bit vector table across all S=R=1 modes.
module tb_sr_using_jk_ff;

    localparam int unsigned NI = 5;
    localparam int unsigned MODES [NI] = '{0, 1, 2, 3, 7};

    logic clk;
    logic rst_n;

    logic s1, r1, q1, qb1, c1;

    logic [3:0] s4, r4;
    logic [3:0] q4 [NI];
    logic [3:0] qb4 [NI];
    logic [3:0] c4 [NI];

    int checks;
    int failures;

    sr_using_jk_ff u_d (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (s1),
        .r          (r1),
        .q          (q1),
        .qbar       (qb1),
        .sr_conflict(c1)
    );

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sr_using_jk_ff #(
            .WIDTH       (4),
            .SR_BOTH_MODE(MODES[g])
        ) u_m (
            .clk        (clk),
            .rst_n      (rst_n),
            .s          (s4),
            .r          (r4),
            .q          (q4[g]),
            .qbar       (qb4[g]),
            .sr_conflict(c4[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s;
        logic [3:0] r;
        logic [3:0] e0;
        logic [3:0] e1;
        logic [3:0] e2;
        logic [3:0] e3;
    } vec_t;

    typedef struct {
        logic [NI-1:0][3:0] q;
        logic [3:0]         conf;
        int                 row;
    } exp_t;

    vec_t tbl [8];
    exp_t sb [$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step1(input logic s_v, input logic r_v);
        @(negedge clk);
        s1 = s_v;
        r1 = r_v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        s1 = 1'b0; r1 = 1'b0;
        s4 = '0;   r4 = '0;

        // Starting values, with S=R=1 applied at 4 bits, q=1 assumed nowhere
        tbl[0] = '{s:4'b1010, r:4'b0110, e0:4'b1000, e1:4'b1010, e2:4'b1010, e3:4'b1000};
        tbl[1] = '{s:4'b1111, r:4'b0000, e0:4'b1111, e1:4'b1111, e2:4'b1111, e3:4'b1111};
        tbl[2] = '{s:4'b1111, r:4'b1111, e0:4'b1111, e1:4'b0000, e2:4'b1111, e3:4'b0000};
        tbl[3] = '{s:4'b1111, r:4'b1111, e0:4'b1111, e1:4'b1111, e2:4'b1111, e3:4'b0000};
        tbl[4] = '{s:4'b0000, r:4'b0101, e0:4'b1010, e1:4'b1010, e2:4'b1010, e3:4'b0000};
        tbl[5] = '{s:4'b0011, r:4'b0110, e0:4'b1011, e1:4'b1001, e2:4'b1011, e3:4'b0001};
        tbl[6] = '{s:4'b0000, r:4'b0000, e0:4'b1011, e1:4'b1001, e2:4'b1011, e3:4'b0001};
        tbl[7] = '{s:4'b1100, r:4'b1010, e0:4'b1101, e1:4'b0101, e2:4'b1101, e3:4'b0101};

        repeat (2) @(negedge clk);
        chk("reset_q", {3'b000, q1}, 4'b0000);
        chk("reset_qbar", {3'b000, qb1}, 4'b0001);
        for (int unsigned i = 0; i < NI; i++) begin
            chk($sformatf("reset_q4_%0d", i), q4[i], 4'b0000);
            chk($sformatf("reset_qbar4_%0d", i), qb4[i], 4'b1111);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step1(1'b0, 1'b0);
            chk($sformatf("hold_q_%0d", i), {3'b000, q1}, 4'b0000);
            chk($sformatf("hold_qbar_%0d", i), {3'b000, qb1}, 4'b0001);
        end

        step1(1'b1, 1'b0);
        chk("set_q", {3'b000, q1}, 4'b0001);
        chk("set_qbar", {3'b000, qb1}, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            step1(1'b1, 1'b0);
            chk($sformatf("set_keep_%0d", i), {3'b000, q1}, 4'b0001);
        end

        step1(1'b1, 1'b1);
        chk("both_hold_q", {3'b000, q1}, 4'b0001);
        chk("both_conflict", {3'b000, c1}, 4'b0001);

        step1(1'b0, 1'b1);
        chk("clear_q", {3'b000, q1}, 4'b0000);
        chk("clear_qbar", {3'b000, qb1}, 4'b0001);
        chk("clear_conflict", {3'b000, c1}, 4'b0000);

        step1(1'b1, 1'b0);
        chk("preset_q", {3'b000, q1}, 4'b0001);
        @(negedge clk);
        s1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_q", {3'b000, q1}, 4'b0000);
        chk("async_reset_qbar", {3'b000, qb1}, 4'b0001);
        s1 = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_held_q", {3'b000, q1}, 4'b0000);
        @(negedge clk);
        s1 = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            @(negedge clk);
            s4 = tbl[i].s;
            r4 = tbl[i].r;
            e.q[0] = tbl[i].e0;
            e.q[1] = tbl[i].e1;
            e.q[2] = tbl[i].e2;
            e.q[3] = tbl[i].e3;
            e.q[4] = tbl[i].e0;
            e.conf = tbl[i].s & tbl[i].r;
            e.row  = i;
            sb.push_back(e);
            #1;
            for (int unsigned m = 0; m < NI; m++)
                chk($sformatf("row%0d_conflict_%0d", i, m), c4[m], e.conf);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty row %0d: got 0 entries expected 1", i);
            end else begin
                exp_t got;
                got = sb.pop_front();
                for (int unsigned m = 0; m < NI; m++) begin
                    chk($sformatf("row%0d_q_mode%0d", got.row, MODES[m]), q4[m], got.q[m]);
                    chk($sformatf("row%0d_qbar_mode%0d", got.row, MODES[m]), qb4[m], ~got.q[m]);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
